// File: rtl/sbmx_seq.sv
// sbmx_seq: iterative SubCells + MixColumn engine. It processes one 16-bit
// column per clock over an NCOL-column state. It uses a valid/ready handshake
// on both sides, an optional mix bypass, and a round-key XOR on each column.

// Combinational transform of a single 16-bit column.
// Nibble 0 is the most significant nibble.
module sbmx_col #(
  parameter logic [63:0] SBOX = 64'h13027E4D9BCFA586
) (
  input  logic [15:0] col,
  input  logic [15:0] key,
  input  logic        skip,
  output logic [15:0] res
);
  // First row of the circulant mix matrix; row i is this row rotated right by i.
  localparam logic [3:0] MB [4] = '{4'h1, 4'h2, 4'h9, 4'h4};

  // S(x) is nibble x counted from the MSB of SBOX.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[{~x, 2'b00} +: 4];
  endfunction

  // Multiply by x in GF(2^4) mod x^4+x+1.
  function automatic logic [3:0] xt(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] gmul(input logic [3:0] x, input logic [3:0] cf);
    logic [3:0] acc;
    logic [3:0] p;
    acc = '0;
    p   = x;
    for (int b = 0; b < 4; b++) begin
      if (cf[b]) acc = acc ^ p;
      p = xt(p);
    end
    return acc;
  endfunction

  logic [0:3][3:0] n, s, m;
  assign n = col;

  // S-box each nibble, then mix through the circulant matrix.
  always_comb begin
    s = '0;
    m = '0;
    for (int i = 0; i < 4; i++) s[i] = sbox(n[i]);
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 4; r++)
        m[i] = m[i] ^ gmul(s[r], MB[(r - i + 4) % 4]);
  end

  assign res = (skip ? s : m) ^ key;
endmodule

// Sequencer: latch the state, transform it in place one column per cycle,
// then hold the result until the consumer takes it.
module sbmx_seq #(
  parameter int          NCOL = 4,
  parameter logic [63:0] SBOX = 64'h13027E4D9BCFA586,
  localparam int         W    = 16 * NCOL
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:W-1] a,
  input  logic [0:W-1] k,
  input  logic         skip_mix,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:W-1] c,
  output logic         busy
);
  localparam int             CW   = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam logic [CW-1:0]  LAST = CW'(NCOL - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state;
  logic [CW-1:0]          cnt;
  logic [0:NCOL-1][15:0]  data;   // working state; column 0 is the MSB column
  logic [0:NCOL-1][15:0]  key;
  logic                   skip;
  logic [15:0]            col_res;

  sbmx_col #(.SBOX(SBOX)) u_col (
    .col  (data[cnt]),
    .key  (key[cnt]),
    .skip (skip),
    .res  (col_res)
  );

  // The working register doubles as the output, so c is stable in DONE.
  assign c = data;

  // Handshake FSM and in-place column update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      data      <= '0;
      key       <= '0;
      skip      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data     <= a;
            key      <= k;
            skip     <= skip_mix;
            cnt      <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            state    <= RUN;
          end else begin
            // Registered ready: rises one edge after reset release.
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          data[cnt] <= col_res;
          if (cnt == LAST) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sbmx_seq.sv
// Directed bench for sbmx_seq: default NCOL=4 instance plus NCOL=1 and NCOL=8
// instances sharing clock and reset.
module tb_sbmx_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // NCOL=4
  logic        in_valid = 0, in_ready, skip_mix = 0, out_valid, out_ready = 0, busy;
  logic [0:63] a = '0, k = '0, c;
  // NCOL=1
  logic        in_valid1 = 0, in_ready1, out_valid1, out_ready1 = 0, busy1;
  logic [0:15] a1 = '0, k1 = '0, c1;
  // NCOL=8
  logic        in_valid8 = 0, in_ready8, out_valid8, out_ready8 = 0, busy8;
  logic [0:127] a8 = '0, k8 = '0, c8;
  logic        skip0 = 0;

  sbmx_seq #(.NCOL(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .k(k),
    .skip_mix(skip_mix), .out_valid(out_valid), .out_ready(out_ready), .c(c), .busy(busy));
  sbmx_seq #(.NCOL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .k(k1),
    .skip_mix(skip0), .out_valid(out_valid1), .out_ready(out_ready1), .c(c1), .busy(busy1));
  sbmx_seq #(.NCOL(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .k(k8),
    .skip_mix(skip0), .out_valid(out_valid8), .out_ready(out_ready8), .c(c8), .busy(busy8));

  // Present one input at a negedge, then count edges until out_valid (bounded).
  task automatic do_op(input logic [0:63] av, input logic [0:63] kv, input logic sv,
                       output int lat, output logic [0:63] res);
    a = av; k = kv; skip_mix = sv; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    res = c;
  endtask

  task automatic take();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (c !== 64'h0) begin errors++; $display("FAIL rst_c got %h exp 0", c); end
    rst_n = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rel_in_ready_early got %b exp 0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rel_out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_zero();
    int lat; logic [0:63] r;
    do_op(64'h0, 64'h0, 1'b0, lat, r);
    checks++; if (lat !== 4) begin errors++; $display("FAIL zero_latency got %0d exp 4", lat); end
    checks++; if (r !== 64'hEEEE_EEEE_EEEE_EEEE) begin errors++; $display("FAIL zero_c got %h exp EEEEEEEEEEEEEEEE", r); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_done got %b exp 0", busy); end
    take();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_ov_after_take got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_ir_after_take got %b exp 1", in_ready); end
  endtask

  task automatic test_single_nibble();
    int lat; logic [0:63] r;
    do_op(64'h0222_2222_2222_2222, 64'h0, 1'b0, lat, r);
    checks++; if (r !== 64'h1492_0000_0000_0000) begin errors++; $display("FAIL nib_c got %h exp 1492000000000000", r); end
    take();
    do_op(64'h0222_2222_2222_2222, 64'hFFFF_0000_0000_0001, 1'b0, lat, r);
    checks++; if (r !== 64'hEB6D_0000_0000_0001) begin errors++; $display("FAIL nib_key_c got %h exp EB6D000000000001", r); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL nib_key_latency got %0d exp 4", lat); end
    take();
  endtask

  task automatic test_bypass_backpressure();
    int lat; int bad; logic [0:63] r;
    do_op(64'h0123_4567_89AB_CDEF, 64'h0, 1'b1, lat, r);
    checks++; if (r !== 64'h1302_7E4D_9BCF_A586) begin errors++; $display("FAIL bypass_c got %h exp 13027E4D9BCFA586", r); end
    a = 64'hFFFF_FFFF_FFFF_FFFF; k = 64'h0; skip_mix = 0; in_valid = 1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (c !== 64'h1302_7E4D_9BCF_A586 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles exp 0", bad); end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_ov got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_not_accepted got busy %b exp 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ir got %b exp 1", in_ready); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL second_accept got busy %b exp 1", busy); end
    // Changes after the accept edge must be ignored.
    in_valid = 0; a = 64'h0; k = 64'hFFFF_FFFF_FFFF_FFFF; skip_mix = 1;
    lat = 0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    checks++; if (lat !== 4) begin errors++; $display("FAIL second_latency got %0d exp 4", lat); end
    checks++; if (c !== 64'h2222_2222_2222_2222) begin errors++; $display("FAIL second_c got %h exp 2222222222222222", c); end
    skip_mix = 0; k = 64'h0;
    take();
  endtask

  task automatic test_midrun_reset();
    int lat; int bad; logic [0:63] r;
    a = 64'h0; k = 64'h0; skip_mix = 0; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b exp 1", busy); end
    rst_n = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrun_rst_busy got %b exp 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrun_rst_ov got %b exp 0", out_valid); end
    checks++; if (c !== 64'h0) begin errors++; $display("FAIL midrun_rst_c got %h exp 0", c); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    bad = 0;
    repeat (8) begin @(negedge clk); if (out_valid !== 1'b0 || busy !== 1'b0) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL midrun_no_emit got %0d bad cycles exp 0", bad); end
    do_op(64'h2222_2222_2222_2222, 64'h0, 1'b0, lat, r);
    checks++; if (r !== 64'h0) begin errors++; $display("FAIL midrun_next_c got %h exp 0", r); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrun_next_latency got %0d exp 4", lat); end
    take();
  endtask

  task automatic test_param_sweep();
    int lat;
    in_valid1 = 1; a1 = 16'h0;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 0;
    lat = 0;
    while (!out_valid1 && lat < 50) begin @(negedge clk); lat++; end
    checks++; if (lat !== 1) begin errors++; $display("FAIL ncol1_latency got %0d exp 1", lat); end
    checks++; if (c1 !== 16'hEEEE) begin errors++; $display("FAIL ncol1_c got %h exp EEEE", c1); end
    out_ready1 = 1; @(negedge clk); out_ready1 = 0;
    in_valid8 = 1; a8 = '0;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 0;
    lat = 0;
    while (!out_valid8 && lat < 50) begin @(negedge clk); lat++; end
    checks++; if (lat !== 8) begin errors++; $display("FAIL ncol8_latency got %0d exp 8", lat); end
    checks++; if (c8 !== {8{16'hEEEE}}) begin errors++; $display("FAIL ncol8_c got %h exp all E", c8); end
    out_ready8 = 1; @(negedge clk); out_ready8 = 0;
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL ncol8_take got %b exp 0", out_valid8); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_single_nibble();
    test_bypass_backpressure();
    test_midrun_reset();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
